// File: rtl/sd_dma_if.sv
// Bus bundle between a host/SD/memory environment and the SD DMA controller.
// The master side drives requests and completions; the slave side is the controller.
interface sd_dma_if;
    logic [31:0]   mem_start_addr;
    logic [31:0]   sd_block_start_addr;
    logic [31:0]   num_blocks;
    logic [31:0]   ctrl_data;
    logic          ctrl_write;
    logic          status_clear;
    logic          mem_ready_set;
    logic          sd_ready_set;
    logic [31:0]   mem_data_in;
    logic [4095:0] sd_data_block_in;
    logic          sd_data_block_in_valid;
    logic [31:0]   ctrl;
    logic [31:0]   status;
    logic [31:0]   error_code;
    logic [31:0]   mem_request_addr_out;
    logic [31:0]   mem_request_data;
    logic          mem_request_read;
    logic          mem_request_write;
    logic [4095:0] sd_data_block_out;
    logic          waiting_for_sd_ready_out;
    logic          init_waiting_for_sd_ready;
    logic [31:0]   current_sd_block_addr;

    modport master (
        output mem_start_addr, sd_block_start_addr, num_blocks, ctrl_data, ctrl_write,
               status_clear, mem_ready_set, sd_ready_set, mem_data_in,
               sd_data_block_in, sd_data_block_in_valid,
        input  ctrl, status, error_code, mem_request_addr_out, mem_request_data,
               mem_request_read, mem_request_write, sd_data_block_out,
               waiting_for_sd_ready_out, init_waiting_for_sd_ready, current_sd_block_addr
    );

    modport slave (
        input  mem_start_addr, sd_block_start_addr, num_blocks, ctrl_data, ctrl_write,
               status_clear, mem_ready_set, sd_ready_set, mem_data_in,
               sd_data_block_in, sd_data_block_in_valid,
        output ctrl, status, error_code, mem_request_addr_out, mem_request_data,
               mem_request_read, mem_request_write, sd_data_block_out,
               waiting_for_sd_ready_out, init_waiting_for_sd_ready, current_sd_block_addr
    );
endinterface

// File: rtl/sd_dma_controller.sv
// Block DMA between an SD card (512-byte blocks) and word-addressed RAM.
// A 128-word staging buffer sits between the SD block port and the RAM beat port.
module sd_dma_controller (
    input  logic    clk,
    input  logic    rst,
    sd_dma_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_INIT_WAIT, S_SD_WAIT, S_MEM_XFER} state_t;

    state_t        r_state, w_state_next;
    logic          r_dir, w_dir_next, r_irq_en, w_irq_en_next;
    logic          r_busy, w_busy_next, r_done, w_done_next, r_err, w_err_next;
    logic          r_initialized, w_initialized_next, r_pending, w_pending_next;
    logic          r_read, w_read_next, r_write, w_write_next;
    logic          r_waiting, w_waiting_next, r_init_waiting, w_init_waiting_next;
    logic [31:0]   r_error_code, w_error_code_next, r_addr, w_addr_next;
    logic [31:0]   r_blk_addr, w_blk_addr_next, r_blocks_left, w_blocks_left_next;
    logic [31:0]   r_mem_data, w_mem_data_next;
    logic [6:0]    r_idx, w_idx_next;
    logic [4095:0] r_buf, w_buf_next;
    logic          w_beat;
    logic          w_unused;

    assign w_unused = ^bus.ctrl_data[31:4];

    always_comb begin
        w_state_next        = r_state;
        w_dir_next          = r_dir;
        w_irq_en_next       = r_irq_en;
        w_done_next         = r_done;
        w_err_next          = r_err;
        w_error_code_next   = r_error_code;
        w_initialized_next  = r_initialized;
        w_pending_next      = r_pending;
        w_read_next         = r_read;
        w_write_next        = r_write;
        w_waiting_next      = r_waiting;
        w_init_waiting_next = r_init_waiting;
        w_addr_next         = r_addr;
        w_blk_addr_next     = r_blk_addr;
        w_blocks_left_next  = r_blocks_left;
        w_idx_next          = r_idx;
        w_buf_next          = r_buf;
        w_beat              = 1'b0;

        // Clearing first lets any same-cycle event below override it.
        if (bus.status_clear) begin
            w_done_next       = 1'b0;
            w_err_next        = 1'b0;
            w_error_code_next = 32'd0;
        end

        case (r_state)
            S_IDLE: begin
                if (bus.ctrl_write) begin
                    w_dir_next    = bus.ctrl_data[1];
                    w_irq_en_next = bus.ctrl_data[2];
                    if (bus.ctrl_data[3]) begin
                        w_state_next        = S_INIT_WAIT;
                        w_init_waiting_next = 1'b1;
                        w_done_next         = 1'b0;
                        w_err_next          = 1'b0;
                        w_error_code_next   = 32'd0;
                    end else if (bus.ctrl_data[0]) begin
                        w_done_next = 1'b1;
                        w_err_next  = 1'b1;
                        if (!r_initialized) begin
                            w_error_code_next = 32'd3;
                        end else if (bus.num_blocks == 32'd0) begin
                            w_error_code_next = 32'd2;
                        end else begin
                            w_done_next        = 1'b0;
                            w_err_next         = 1'b0;
                            w_error_code_next  = 32'd0;
                            w_addr_next        = bus.mem_start_addr;
                            w_blk_addr_next    = bus.sd_block_start_addr;
                            w_blocks_left_next = bus.num_blocks;
                            w_idx_next         = 7'd0;
                            w_pending_next     = 1'b0;
                            if (bus.ctrl_data[1]) begin
                                w_state_next = S_MEM_XFER;
                                w_read_next  = 1'b1;
                            end else begin
                                w_state_next   = S_SD_WAIT;
                                w_waiting_next = 1'b1;
                            end
                        end
                    end
                end
            end
            S_INIT_WAIT: begin
                if (bus.sd_ready_set) begin
                    w_state_next        = S_IDLE;
                    w_init_waiting_next = 1'b0;
                    w_done_next         = 1'b1;
                    w_initialized_next  = 1'b1;
                end
            end
            S_SD_WAIT: begin
                if (!r_dir) begin
                    if (bus.sd_data_block_in_valid)
                        w_buf_next = bus.sd_data_block_in;
                    if (bus.sd_ready_set) begin
                        w_state_next   = S_MEM_XFER;
                        w_waiting_next = 1'b0;
                        w_write_next   = 1'b1;
                    end
                end else begin
                    // RAM beats arriving while the SD write is in flight are remembered once.
                    if (bus.mem_ready_set)
                        w_pending_next = 1'b1;
                    if (bus.sd_ready_set) begin
                        w_waiting_next = 1'b0;
                        if (r_blocks_left == 32'd1) begin
                            w_state_next = S_IDLE;
                            w_done_next  = 1'b1;
                        end else begin
                            w_state_next       = S_MEM_XFER;
                            w_read_next        = 1'b1;
                            w_blk_addr_next    = r_blk_addr + 32'd1;
                            w_blocks_left_next = r_blocks_left - 32'd1;
                            w_idx_next         = 7'd0;
                        end
                    end
                end
            end
            S_MEM_XFER: begin
                w_beat = bus.mem_ready_set | r_pending;
                if (r_pending && !bus.mem_ready_set)
                    w_pending_next = 1'b0;
                if (w_beat) begin
                    if (r_dir)
                        w_buf_next[{r_idx, 5'd0} +: 32] = bus.mem_data_in;
                    w_idx_next  = r_idx + 7'd1;
                    w_addr_next = r_addr + 32'd4;
                    if (r_idx == 7'd127) begin
                        if (r_dir) begin
                            w_state_next   = S_SD_WAIT;
                            w_read_next    = 1'b0;
                            w_waiting_next = 1'b1;
                        end else begin
                            w_write_next = 1'b0;
                            if (r_blocks_left == 32'd1) begin
                                w_state_next = S_IDLE;
                                w_done_next  = 1'b1;
                            end else begin
                                w_state_next       = S_SD_WAIT;
                                w_waiting_next     = 1'b1;
                                w_blk_addr_next    = r_blk_addr + 32'd1;
                                w_blocks_left_next = r_blocks_left - 32'd1;
                            end
                        end
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase

        w_busy_next     = (w_state_next != S_IDLE);
        w_mem_data_next = w_buf_next[{w_idx_next, 5'd0} +: 32];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_dir          <= 1'b0;
            r_irq_en       <= 1'b0;
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err          <= 1'b0;
            r_error_code   <= 32'd0;
            r_initialized  <= 1'b0;
            r_pending      <= 1'b0;
            r_read         <= 1'b0;
            r_write        <= 1'b0;
            r_waiting      <= 1'b0;
            r_init_waiting <= 1'b0;
            r_addr         <= 32'd0;
            r_blk_addr     <= 32'd0;
            r_blocks_left  <= 32'd0;
            r_idx          <= 7'd0;
            r_buf          <= '0;
            r_mem_data     <= 32'd0;
        end else begin
            r_state        <= w_state_next;
            r_dir          <= w_dir_next;
            r_irq_en       <= w_irq_en_next;
            r_busy         <= w_busy_next;
            r_done         <= w_done_next;
            r_err          <= w_err_next;
            r_error_code   <= w_error_code_next;
            r_initialized  <= w_initialized_next;
            r_pending      <= w_pending_next;
            r_read         <= w_read_next;
            r_write        <= w_write_next;
            r_waiting      <= w_waiting_next;
            r_init_waiting <= w_init_waiting_next;
            r_addr         <= w_addr_next;
            r_blk_addr     <= w_blk_addr_next;
            r_blocks_left  <= w_blocks_left_next;
            r_idx          <= w_idx_next;
            r_buf          <= w_buf_next;
            r_mem_data     <= w_mem_data_next;
        end
    end

    assign bus.ctrl                      = {29'd0, r_irq_en, r_dir, 1'b0};
    assign bus.status                    = {29'd0, r_err, r_done, r_busy};
    assign bus.error_code                = r_error_code;
    assign bus.mem_request_addr_out      = r_addr;
    assign bus.mem_request_data          = r_mem_data;
    assign bus.mem_request_read          = r_read;
    assign bus.mem_request_write         = r_write;
    assign bus.sd_data_block_out         = r_buf;
    assign bus.waiting_for_sd_ready_out  = r_waiting;
    assign bus.init_waiting_for_sd_ready = r_init_waiting;
    assign bus.current_sd_block_addr     = r_blk_addr;
endmodule

// File: tb/tb_sd_dma_controller.sv
// Directed bench for sd_dma_controller: error paths, init, one-block SD->RAM,
// two-block RAM->SD with dropped extra beats, and reset during a transfer.
module tb_sd_dma_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    logic [31:0]   sb[$];
    logic [31:0]   exp_word;
    logic [31:0]   val;
    logic [4095:0] blk;

    sd_dma_if dma_if ();

    sd_dma_controller dut (
        .clk (clk),
        .rst (rst),
        .bus (dma_if)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic ctrl_wr(input logic [31:0] data);
        dma_if.ctrl_data  = data;
        dma_if.ctrl_write = 1'b1;
        tick();
        dma_if.ctrl_write = 1'b0;
    endtask

    task automatic sd_ready();
        dma_if.sd_ready_set = 1'b1;
        tick();
        dma_if.sd_ready_set = 1'b0;
    endtask

    task automatic st_clear();
        dma_if.status_clear = 1'b1;
        tick();
        dma_if.status_clear = 1'b0;
    endtask

    initial begin
        dma_if.mem_start_addr         = 32'd0;
        dma_if.sd_block_start_addr    = 32'd0;
        dma_if.num_blocks             = 32'd0;
        dma_if.ctrl_data              = 32'd0;
        dma_if.ctrl_write             = 1'b0;
        dma_if.status_clear           = 1'b0;
        dma_if.mem_ready_set          = 1'b0;
        dma_if.sd_ready_set           = 1'b0;
        dma_if.mem_data_in            = 32'd0;
        dma_if.sd_data_block_in       = '0;
        dma_if.sd_data_block_in_valid = 1'b0;

        tick();
        tick();
        rst = 1'b0;
        tick();
        check("rst_status", dma_if.status, 32'd0);
        check("rst_ctrl", dma_if.ctrl, 32'd0);
        check("rst_code", dma_if.error_code, 32'd0);
        check("rst_buf0", dma_if.sd_data_block_out[31:0], 32'd0);
        check("rst_rw", {30'd0, dma_if.mem_request_read, dma_if.mem_request_write}, 32'd0);

        // START before SD_INIT
        dma_if.num_blocks = 32'd1;
        ctrl_wr(32'h1);
        check("noinit_status", dma_if.status, 32'h6);
        check("noinit_code", dma_if.error_code, 32'd3);
        st_clear();
        check("clr_status", dma_if.status, 32'd0);
        check("clr_code", dma_if.error_code, 32'd0);

        // SD init handshake
        ctrl_wr(32'h8);
        check("init_status", dma_if.status, 32'h1);
        check("init_wait", dma_if.init_waiting_for_sd_ready, 32'd1);
        sd_ready();
        check("init_done_status", dma_if.status, 32'h2);
        check("init_done_code", dma_if.error_code, 32'd0);
        check("init_wait_clr", dma_if.init_waiting_for_sd_ready, 32'd0);

        // zero-length transfer
        dma_if.num_blocks = 32'd0;
        ctrl_wr(32'h1);
        check("zero_status", dma_if.status, 32'h6);
        check("zero_code", dma_if.error_code, 32'd2);

        // SD -> RAM, one block
        dma_if.mem_start_addr      = 32'h1000;
        dma_if.sd_block_start_addr = 32'd5;
        dma_if.num_blocks          = 32'd1;
        ctrl_wr(32'h1);
        check("rd_status", dma_if.status, 32'h1);
        check("rd_code_clr", dma_if.error_code, 32'd0);
        check("rd_waiting", dma_if.waiting_for_sd_ready_out, 32'd1);
        check("rd_write0", dma_if.mem_request_write, 32'd0);
        check("rd_blk", dma_if.current_sd_block_addr, 32'd5);
        for (int k = 0; k < 128; k++) begin
            val = (k == 0) ? 32'hDEADBEEF : (k == 1) ? 32'h12345678 : $urandom;
            blk[k*32 +: 32] = val;
            sb.push_back(val);
        end
        dma_if.sd_data_block_in       = blk;
        dma_if.sd_data_block_in_valid = 1'b1;
        tick();
        dma_if.sd_data_block_in_valid = 1'b0;
        sd_ready();
        check("rd_write1", dma_if.mem_request_write, 32'd1);
        check("rd_waiting_clr", dma_if.waiting_for_sd_ready_out, 32'd0);
        for (int k = 0; k < 128; k++) begin
            exp_word = sb.pop_front();
            check($sformatf("rd_data%0d", k), dma_if.mem_request_data, exp_word);
            check($sformatf("rd_addr%0d", k), dma_if.mem_request_addr_out, 32'h1000 + 32'(4 * k));
            dma_if.mem_ready_set = 1'b1;
            if (k == 10) begin
                dma_if.ctrl_data  = 32'h6;
                dma_if.ctrl_write = 1'b1;
            end
            if (k == 64) dma_if.status_clear = 1'b1;
            tick();
            dma_if.mem_ready_set = 1'b0;
            dma_if.ctrl_write    = 1'b0;
            dma_if.status_clear  = 1'b0;
            if (k == 10) check("busy_ctrl_ignored", dma_if.ctrl, 32'd0);
            if (k == 64) check("clr_keeps_busy", dma_if.status, 32'h1);
        end
        check("rd_end_status", dma_if.status, 32'h2);
        check("rd_end_write", dma_if.mem_request_write, 32'd0);
        check("rd_end_addr", dma_if.mem_request_addr_out, 32'h1200);

        // RAM -> SD, two blocks
        dma_if.mem_start_addr      = 32'h2000;
        dma_if.sd_block_start_addr = 32'd10;
        dma_if.num_blocks          = 32'd2;
        ctrl_wr(32'h3);
        check("wr_read", dma_if.mem_request_read, 32'd1);
        check("wr_status", dma_if.status, 32'h1);
        check("wr_ctrl", dma_if.ctrl, 32'h2);
        check("wr_addr0", dma_if.mem_request_addr_out, 32'h2000);
        for (int k = 0; k < 128; k++) begin
            val = $urandom;
            sb.push_back(val);
            dma_if.mem_data_in   = val;
            dma_if.mem_ready_set = 1'b1;
            tick();
        end
        dma_if.mem_ready_set = 1'b0;
        check("wr_wait0", dma_if.waiting_for_sd_ready_out, 32'd1);
        check("wr_read_off", dma_if.mem_request_read, 32'd0);
        check("wr_addr_blk0", dma_if.mem_request_addr_out, 32'h2200);
        for (int k = 0; k < 128; k++) begin
            exp_word = sb.pop_front();
            check($sformatf("wr_b0w%0d", k), dma_if.sd_data_block_out[k*32 +: 32], exp_word);
        end
        for (int p = 0; p < 9; p++) begin
            dma_if.mem_ready_set = 1'b1;
            tick();
            dma_if.mem_ready_set = 1'b0;
            tick();
        end
        check("wr_addr_held", dma_if.mem_request_addr_out, 32'h2200);
        check("wr_still_wait", dma_if.waiting_for_sd_ready_out, 32'd1);
        val = 32'hC0FFEE01;
        sb.push_back(val);
        dma_if.mem_data_in = val;
        sd_ready();
        check("wr_blk1", dma_if.current_sd_block_addr, 32'd11);
        check("wr_read_resume", dma_if.mem_request_read, 32'd1);
        tick();
        check("wr_replay_addr", dma_if.mem_request_addr_out, 32'h2204);
        for (int k = 1; k < 128; k++) begin
            val = $urandom;
            sb.push_back(val);
            dma_if.mem_data_in   = val;
            dma_if.mem_ready_set = 1'b1;
            tick();
        end
        dma_if.mem_ready_set = 1'b0;
        check("wr_wait1", dma_if.waiting_for_sd_ready_out, 32'd1);
        check("wr_addr_blk1", dma_if.mem_request_addr_out, 32'h2400);
        for (int k = 0; k < 128; k++) begin
            exp_word = sb.pop_front();
            check($sformatf("wr_b1w%0d", k), dma_if.sd_data_block_out[k*32 +: 32], exp_word);
        end
        sd_ready();
        check("wr_end_status", dma_if.status, 32'h2);
        check("wr_end_wait", dma_if.waiting_for_sd_ready_out, 32'd0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        // reset during a transfer drops initialization
        dma_if.num_blocks = 32'd1;
        ctrl_wr(32'h1);
        check("pre_rst_busy", dma_if.status, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_status", dma_if.status, 32'd0);
        check("mid_rst_wait", dma_if.waiting_for_sd_ready_out, 32'd0);
        ctrl_wr(32'h1);
        check("post_rst_code", dma_if.error_code, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sd_dma_controller.md
SD_DMA_CONTROLLER -- requirements
Module: sd_dma_controller

Interface
REQ-001 Parameters: none; block size SHALL be fixed at 128 x 32-bit words (512 bytes); one clock; reset synchronous, active-high.
REQ-002 clk  in  1  sole clock, all state updates on rising edge.
REQ-003 rst  in  1  synchronous active-high reset.
REQ-004 mem_start_addr  in  32  RAM byte address of first word.
REQ-005 sd_block_start_addr  in  32  first SD block index.
REQ-006 num_blocks  in  32  blocks to transfer.
REQ-007 ctrl_data  in  32  CTRL write data: bit0 START, bit1 DIR (0 SD->RAM, 1 RAM->SD), bit2 IRQ_EN, bit3 SD_INIT.
REQ-008 ctrl_write  in  1  one-cycle CTRL write strobe.
REQ-009 status_clear  in  1  clear DONE/ERR strobe.
REQ-010 mem_ready_set  in  1  current memory beat completed.
REQ-011 sd_ready_set  in  1  SD side finished init/block operation.
REQ-012 mem_data_in  in  32  read data for current memory beat.
REQ-013 sd_data_block_in  in  4096  block read from SD, word k at bits [32k+31:32k].
REQ-014 sd_data_block_in_valid  in  1  sd_data_block_in valid strobe.
REQ-015 ctrl  out  32  {29'b0, IRQ_EN, DIR, 1'b0}; START/SD_INIT read as 0.
REQ-016 status  out  32  bit0 BUSY, bit1 DONE, bit2 ERR, others 0.
REQ-017 error_code  out  32  0 none, 2 num_blocks==0, 3 START before init.
REQ-018 mem_request_addr_out  out  32  current RAM byte address.
REQ-019 mem_request_data  out  32  buffer word at current index.
REQ-020 mem_request_read  out  1  RAM read request active.
REQ-021 mem_request_write  out  1  RAM write request active.
REQ-022 sd_data_block_out  out  4096  staged block buffer (continuous).
REQ-023 waiting_for_sd_ready_out  out  1  transfer stalled for sd_ready_set.
REQ-024 init_waiting_for_sd_ready  out  1  SD init pending.
REQ-025 current_sd_block_addr  out  32  SD block index in progress.

Function
REQ-026 States: IDLE, INIT_WAIT, SD_WAIT, MEM_XFER; BUSY=1 in all but IDLE; all outputs registered.
REQ-027 ctrl_write in IDLE: SD_INIT has priority -> INIT_WAIT, BUSY=1, init_waiting=1, DONE/ERR/error_code cleared; IRQ_EN/DIR latched on every ctrl_write.
REQ-028 INIT_WAIT + sd_ready_set -> IDLE, BUSY=0, DONE=1, initialized flag set (cleared only by rst).
REQ-029 START in IDLE, not initialized -> stay IDLE, DONE=1, ERR=1, error_code=3; initialized and num_blocks==0 -> DONE=1, ERR=1, code 2.
REQ-030 Valid START: clear DONE/ERR/code, addr=mem_start_addr, current_sd_block_addr=sd_block_start_addr, word index 0, BUSY=1; DIR=0 -> SD_WAIT (read=write=0, waiting=1); DIR=1 -> MEM_XFER with read=1.
REQ-031 ctrl_write while BUSY ignored (only IRQ_EN/DIR readback unaffected during transfer: latched DIR kept).
REQ-032 DIR=0: sd_data_block_in_valid in SD_WAIT loads buffer; sd_ready_set -> MEM_XFER, waiting=0, write=1, data=buffer word 0.
REQ-033 MEM_XFER + mem_ready_set: DIR=1 stores mem_data_in into buffer[index]; then index+1, addr+4; mem_request_data tracks buffer[index].
REQ-034 After word 127: DIR=0 -> last block: IDLE, write=0, BUSY=0, DONE=1; else block+1, index 0, SD_WAIT. DIR=1 -> SD_WAIT, read=0, waiting=1, addr held.
REQ-035 DIR=1 SD_WAIT + sd_ready_set: last block -> IDLE, DONE=1; else block+1, index 0, MEM_XFER, read=1.
REQ-036 DIR=1 SD_WAIT: mem_ready_set sets single saturating pending flag (extra pulses dropped); replayed as one beat within 2 cycles after resume, then cleared.
REQ-037 status_clear clears DONE, ERR, error_code; never BUSY; ctrl_write same cycle wins for its fields.
REQ-038 mem_ready_set/sd_ready_set/valid outside the states above ignored; addresses wrap mod 2^32.

Reset
REQ-039 rst: IDLE, all outputs 0, buffer 0, pending and initialized flags 0; overrides any in-flight transfer.

Verification
REQ-040 START (DIR=0) before SD_INIT -> BUSY=0, DONE=1, ERR=1, error_code=3.
REQ-041 SD_INIT -> BUSY=1, init_waiting=1; sd_ready_set -> BUSY=0, DONE=1, ERR=0, code 0.
REQ-042 DIR=0, 1 block: waiting=1, write=0; load word0=DEADBEEF, word1=12345678, sd_ready -> write=1, data DEADBEEF; mem_ready -> 12345678; 127 more beats -> idle, DONE.
REQ-043 status_clear mid-transfer -> BUSY stays 1.
REQ-044 DIR=1, 2 blocks @0x2000: read=1; 128 beats -> waiting, addr 0x2200 held through 9 extra pulses; sd_ready -> addr advances; 127 beats -> waiting; sd_ready -> BUSY=0, DONE=1.
